program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Produces the processor's byte-entry interface (Input[7:0], Enter, Initialize) automatically, in place of hand-toggled switches.
- Replays a fixed program image from a small ROM into the microprocessor, using the same Enter strobe discipline a user applies with SW[9].
- Sits between the board switches and EC2_microprocessor. Outside a load it passes switch values through, registered.

Parameters:
- LENGTH, 16, number of bytes replayed per load; legal range 1..DEPTH.
- DEPTH, 32, ROM entries; must be a power of two.
- ADDR_W, 5, ROM address width; equals log2(DEPTH).
- GAP_CYCLES, 4, cycles Enter is held low with data stable, before each strobe and after the last one; minimum 1.
- HOLD_CYCLES, 4, cycles Enter is held high per byte; minimum 1.

Ports:
- Clock  input  1  system clock (divided clock, CLOCKOUT domain).
- Reset  input  1  asynchronous, active-low reset.
- Start  input  1  load request, active-high; a load starts on its registered rising edge.
- SwInput  input  8  switch data (SW[7:0]).
- SwEnter  input  1  switch Enter (SW[9]).
- SwInitialize  input  1  switch Initialize (SW[8]).
- ProcInput  output  8  data to processor Input.
- ProcEnter  output  1  Enter to processor.
- ProcInitialize  output  1  Initialize to processor.
- Busy  output  1  high while a load is in progress.
- Done  output  1  high after a load completes, until Start falls.
- ByteIndex  output  ADDR_W  index of the byte currently presented.

Behaviour:
- Reset low, asynchronously: state IDLE; all outputs 0, ByteIndex 0, timer 0, Start edge register 0.
- All outputs are registered. Start is sampled into a register; the rising edge is Start=1 with previous sample 0.
- IDLE:
  - ProcInput<=SwInput, ProcEnter<=SwEnter, ProcInitialize<=SwInitialize (1-cycle latency); Busy=0, Done=0.
  - On Start edge: ByteIndex<=0, timer<=0, go to GAP.
- GAP:
  - ProcInput=rom[ByteIndex], ProcEnter=0, ProcInitialize=1, Busy=1.
  - After GAP_CYCLES cycles in GAP: go to STROBE if bytes remain, else go to DONE.
- STROBE:
  - ProcInput=rom[ByteIndex] held stable, ProcEnter=1, ProcInitialize=1, Busy=1.
  - After HOLD_CYCLES cycles: ProcEnter falls.
  - If ByteIndex==LENGTH-1, set a last flag and go to GAP (trailing gap). Otherwise ByteIndex<=ByteIndex+1 and go to GAP.
- DONE:
  - Pass-through as in IDLE, except Done=1 and Busy=0.
  - When registered Start is 0: go to IDLE and Done<=0.
- Data changes only while ProcEnter=0 and at least GAP_CYCLES before the next rise; never during a strobe.
- Start edges are ignored while Busy=1 or in DONE. A new load requires Start low, then high.
- Switch inputs are ignored while Busy=1.
- Total Busy duration: LENGTH*(GAP_CYCLES+HOLD_CYCLES)+GAP_CYCLES cycles.
- Timer width: ceil(log2(max(GAP_CYCLES,HOLD_CYCLES)+1)). ByteIndex never exceeds LENGTH-1; no wrap.
- Reset mid-load: immediate abort to IDLE with ProcEnter=0 and ProcInitialize=0. A partial image in the processor is acceptable; no resume.

Decomposition:
- Package loader_pkg: state enum (IDLE, GAP, STROBE, DONE) and default program image constants.
- One sub-module, program_rom: combinational read, DEPTH x 8, contents from loader_pkg; unused entries are 8'h00.

Test Plan:
- Reset: Reset=0 while Start=1 -> all outputs 0; after release with Start still high, no load starts (no edge).
- Pass-through: IDLE, SwInput=8'hA5, SwEnter=1, SwInitialize=1 -> ProcInput=8'hA5, ProcEnter=1, ProcInitialize=1 one cycle later.
- Full load, LENGTH=4, GAP_CYCLES=2, HOLD_CYCLES=3, rom={8'h11,8'h22,8'h33,8'h44}:
  - Exactly 4 ProcEnter pulses, each 3 cycles wide, with ProcInput 11,22,33,44 stable 2 cycles before and throughout each pulse.
  - Busy high 22 cycles, then Done=1.
- Retrigger: Start toggled during Busy -> still exactly 4 strobes. In DONE with Start held high -> no restart; Start low -> IDLE, Done=0; Start high -> second identical load.
- Abort: Reset asserted during the 2nd strobe -> ProcEnter=0, ProcInitialize=0, Busy=0 in the same cycle (asynchronous). Next Start -> load begins at ByteIndex 0.
- Switch isolation: SwEnter toggled every cycle during a load -> ProcEnter pattern identical to the clean full-load scenario.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and the default program image for the program loader.
// The image is replayed byte by byte into the processor's entry port.
package loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GAP,
    STROBE,
    DONE
  } state_t;

  localparam int IMG_LEN = 16;

  localparam logic [7:0] IMAGE [IMG_LEN] = '{
    8'h11, 8'h22, 8'h33, 8'h44,
    8'h55, 8'h66, 8'h77, 8'h88,
    8'h99, 8'hAA, 8'hBB, 8'hCC,
    8'hDD, 8'hEE, 8'hF0, 8'h0F
  };

  // Entries past the image read as zero.
  function automatic logic [7:0] img_byte(input int unsigned a);
    return (a < IMG_LEN) ? IMAGE[a[3:0]] : 8'h00;
  endfunction

endpackage

// File: rtl/program_rom.sv
// Combinational DEPTH x 8 program ROM.
// Contents come from the loader package image.
module program_rom
  import loader_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] i_addr,
  output logic [7:0]        o_data
);

  logic [31:0] w_a;

  assign w_a    = 32'(i_addr);
  assign o_data = (w_a < DEPTH) ? img_byte(w_a) : 8'h00;

endmodule

// File: rtl/program_loader.sv
// Replays the ROM image into the processor's Input/Enter/Initialize
// port; passes switch values through (registered) when not loading.
module program_loader
  import loader_pkg::*;
#(
  parameter int LENGTH      = 16,
  parameter int DEPTH       = 32,
  parameter int ADDR_W      = 5,
  parameter int GAP_CYCLES  = 4,
  parameter int HOLD_CYCLES = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [7:0]        SwInput,
  input  logic              SwEnter,
  input  logic              SwInitialize,
  output logic [7:0]        ProcInput,
  output logic              ProcEnter,
  output logic              ProcInitialize,
  output logic              Busy,
  output logic              Done,
  output logic [ADDR_W-1:0] ByteIndex
);

  localparam int MAXC = (GAP_CYCLES > HOLD_CYCLES) ?
                        GAP_CYCLES : HOLD_CYCLES;
  localparam int TW = $clog2(MAXC + 1);
  localparam logic [TW-1:0] GAP_END  = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_END = TW'(HOLD_CYCLES - 1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LENGTH - 1);

  state_t            r_state;
  logic [TW-1:0]     r_timer;
  logic [ADDR_W-1:0] r_idx;
  logic              r_last;
  logic              r_start_low;
  logic [7:0]        r_in;
  logic              r_en;
  logic              r_init;
  logic              r_busy;
  logic              r_done;

  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_rom;
  logic              w_edge;

  // Reset leaves r_start_low clear, so a Start held through reset
  // is not taken as an edge.
  assign w_edge = Start & r_start_low;

  always_comb begin
    w_addr = r_idx;
    unique case (r_state)
      IDLE:    w_addr = '0;
      STROBE:  w_addr = r_idx + ADDR_W'(1);
      default: w_addr = r_idx;
    endcase
  end

  program_rom #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_rom (
    .i_addr(w_addr),
    .o_data(w_rom)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state     <= IDLE;
      r_timer     <= '0;
      r_idx       <= '0;
      r_last      <= 1'b0;
      r_start_low <= 1'b0;
      r_in        <= '0;
      r_en        <= 1'b0;
      r_init      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_start_low <= ~Start;
      unique case (r_state)
        IDLE: begin
          r_in   <= SwInput;
          r_en   <= SwEnter;
          r_init <= SwInitialize;
          r_busy <= 1'b0;
          r_done <= 1'b0;
          if (w_edge) begin
            r_state <= GAP;
            r_idx   <= '0;
            r_timer <= '0;
            r_last  <= 1'b0;
            r_in    <= w_rom;
            r_en    <= 1'b0;
            r_init  <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        GAP: begin
          if (r_timer == GAP_END) begin
            r_timer <= '0;
            if (r_last) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_in    <= SwInput;
              r_en    <= SwEnter;
              r_init  <= SwInitialize;
            end else begin
              r_state <= STROBE;
              r_en    <= 1'b1;
            end
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        STROBE: begin
          if (r_timer == HOLD_END) begin
            r_timer <= '0;
            r_en    <= 1'b0;
            r_state <= GAP;
            if (r_idx == LAST) begin
              r_last <= 1'b1;
            end else begin
              r_idx <= r_idx + ADDR_W'(1);
              r_in  <= w_rom;
            end
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        DONE: begin
          r_in   <= SwInput;
          r_en   <= SwEnter;
          r_init <= SwInitialize;
          r_busy <= 1'b0;
          r_done <= 1'b1;
          if (r_start_low) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ProcInput      = r_in;
  assign ProcEnter      = r_en;
  assign ProcInitialize = r_init;
  assign Busy           = r_busy;
  assign Done           = r_done;
  assign ByteIndex      = r_idx;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: reset, pass-through, full load,
// retrigger, switch isolation and mid-load abort.
module tb_program_loader;

  localparam int L = 4;
  localparam int G = 2;
  localparam int H = 3;
  localparam int BUSY_LEN = L * (G + H) + G;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       Start;
  logic [7:0] SwInput;
  logic       SwEnter;
  logic       SwInitialize;
  logic [7:0] ProcInput;
  logic       ProcEnter;
  logic       ProcInitialize;
  logic       Busy;
  logic       Done;
  logic [4:0] ByteIndex;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] exp_rom [L] = '{8'h11, 8'h22, 8'h33, 8'h44};

  always #5 Clock = ~Clock;

  program_loader #(
    .LENGTH     (L),
    .DEPTH      (32),
    .ADDR_W     (5),
    .GAP_CYCLES (G),
    .HOLD_CYCLES(H)
  ) dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .Start         (Start),
    .SwInput       (SwInput),
    .SwEnter       (SwEnter),
    .SwInitialize  (SwInitialize),
    .ProcInput     (ProcInput),
    .ProcEnter     (ProcEnter),
    .ProcInitialize(ProcInitialize),
    .Busy          (Busy),
    .Done          (Done),
    .ByteIndex     (ByteIndex)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // One complete load; Start must already have been low for a cycle.
  task automatic run_load(input bit tog_start, input bit tog_sw);
    int rises;
    logic prev_en;
    int seg;
    int pos;
    rises   = 0;
    prev_en = 1'b0;
    Start   = 1'b1;
    for (int j = 0; j < BUSY_LEN; j++) begin
      tick();
      seg = (j / (G + H) < L) ? j / (G + H) : L - 1;
      pos = j % (G + H);
      chk("busy", 32'(Busy), 32'd1);
      chk("en", 32'(ProcEnter), 32'((j < L * (G + H)) && pos >= G));
      chk("data", 32'(ProcInput), 32'(exp_rom[seg]));
      chk("idx", 32'(ByteIndex), 32'(seg));
      chk("init", 32'(ProcInitialize), 32'd1);
      if (ProcEnter && !prev_en) rises++;
      prev_en = ProcEnter;
      if (tog_start && j < BUSY_LEN - 1) Start = ~Start;
      if (tog_sw) SwEnter = ~SwEnter;
    end
    chk("rises", 32'(rises), 32'(L));
    if (tog_start) Start = 1'b0;
    SwEnter = 1'b0;
    tick();
    chk("busy_end", 32'(Busy), 32'd0);
    chk("done_end", 32'(Done), 32'd1);
  endtask

  initial begin
    Reset        = 1'b0;
    Start        = 1'b1;
    SwInput      = 8'h5A;
    SwEnter      = 1'b1;
    SwInitialize = 1'b1;
    #3;
    chk("rst_in", 32'(ProcInput), 32'd0);
    chk("rst_en", 32'(ProcEnter), 32'd0);
    chk("rst_init", 32'(ProcInitialize), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_idx", 32'(ByteIndex), 32'd0);
    tick();
    tick();
    Reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("no_edge_busy", 32'(Busy), 32'd0);
    end
    chk("pt_5a", 32'(ProcInput), 32'h5A);

    Start        = 1'b0;
    SwInput      = 8'h00;
    SwEnter      = 1'b0;
    SwInitialize = 1'b0;
    tick();
    SwInput      = 8'hA5;
    SwEnter      = 1'b1;
    SwInitialize = 1'b1;
    chk("pt_lat", 32'(ProcInput), 32'h00);
    tick();
    chk("pt_in", 32'(ProcInput), 32'hA5);
    chk("pt_en", 32'(ProcEnter), 32'd1);
    chk("pt_init", 32'(ProcInitialize), 32'd1);
    SwInput      = 8'h00;
    SwEnter      = 1'b0;
    SwInitialize = 1'b0;
    tick();

    run_load(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_done", 32'(Done), 32'd1);
      chk("hold_busy", 32'(Busy), 32'd0);
    end
    Start = 1'b0;
    tick();
    tick();
    chk("idle_done", 32'(Done), 32'd0);
    chk("idle_busy", 32'(Busy), 32'd0);

    run_load(1'b1, 1'b0);
    Start = 1'b0;
    tick();
    tick();
    chk("rt_idle", 32'(Done), 32'd0);

    run_load(1'b0, 1'b1);
    Start = 1'b0;
    tick();
    tick();
    chk("iso_idle", 32'(Done), 32'd0);

    Start = 1'b1;
    for (int j = 0; j < 8; j++) tick();
    chk("ab_pre_en", 32'(ProcEnter), 32'd1);
    chk("ab_pre_idx", 32'(ByteIndex), 32'd1);
    #2;
    Reset = 1'b0;
    #1;
    chk("ab_en", 32'(ProcEnter), 32'd0);
    chk("ab_init", 32'(ProcInitialize), 32'd0);
    chk("ab_busy", 32'(Busy), 32'd0);
    chk("ab_idx", 32'(ByteIndex), 32'd0);
    #4;
    Reset = 1'b1;
    Start = 1'b0;
    tick();
    tick();
    run_load(1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
